// File: rtl/alu_pkg.sv
// Shared opcode/state types for the multi-cycle ALU and its iterative engine.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_MUL   = 4'b0110,
        OP_XOR   = 4'b0111,
        OP_SLT   = 4'b1000,
        OP_NOT   = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_MOVB  = 4'b1011,
        OP_SRA   = 4'b1100,
        OP_MOD   = 4'b1101,
        OP_SLTS  = 4'b1110,
        OP_MULHU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(alu_op_e op);
        return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_MOD};
    endfunction

    function automatic logic is_divide(alu_op_e op);
        return op inside {OP_DIV, OP_MOD};
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared radix-2 shift-add multiplier / restoring divider; the first step
// is taken on the start edge so XLEN steps finish inside XLEN BUSY cycles.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi
);

    localparam int CW = $clog2(XLEN);

    logic            busy_q, busy_d;
    logic            div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;

    logic [XLEN-1:0] cur_hi, cur_lo, cur_opnd;
    logic            cur_div;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [XLEN-1:0] step_hi, step_lo;
    logic            last;

    // One iteration, fed from the raw operands on start and from the registers afterwards.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
        cur_hi    = start ? '0 : hi_q;
        cur_lo    = start ? a : lo_q;
        cur_opnd  = start ? b : opnd_q;
        cur_div   = start ? is_divide(op) : div_q;
        mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opnd} : '0);
        div_trial = {cur_hi, cur_lo[XLEN-1]};
        step_hi   = mul_sum[XLEN:1];
        step_lo   = {mul_sum[0], cur_lo[XLEN-1:1]};
        if (cur_div) begin
            if (div_trial >= {1'b0, cur_opnd}) begin
                step_hi = XLEN'(div_trial - {1'b0, cur_opnd});
                step_lo = {cur_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_trial[XLEN-1:0];
                step_lo = {cur_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign last = busy_q && (cnt_q == CW'(XLEN - 1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            div_d  = is_divide(op);
            hi_d   = step_hi;
            lo_d   = step_lo;
            opnd_d = b;
        end else if (last) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            hi_d  = step_hi;
            lo_d  = step_lo;
        end
    end

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: datapath registers are left unreset; start always loads them before they are read.
    always_ff @(posedge clk) begin
        div_q  <= div_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
    end

    assign done      = last;
    assign result_lo = lo_q;
    assign result_hi = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, single-cycle op unit and registered outputs;
// MUL/MULHU/DIV/MOD are delegated to alu_iter_core.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero_flag,
    output logic            div_by_zero
);

    localparam int SW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    alu_op_e         op_in, op_q;
    logic            b_zero_q;
    logic            out_valid_q, zero_q, dbz_q;
    logic [XLEN-1:0] result_q;

    logic            accept, core_start, load_simple, load_iter, core_done;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] simple_res, iter_res, core_lo, core_hi;

    assign op_in = alu_op_e'(alu_control);
    assign shamt = B[SW-1:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = is_iterative(op_in) ? ST_BUSY : ST_DONE;
        end else begin
            case (state_q)
                ST_BUSY: if (core_done) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
        accept      = in_valid && in_ready;
        core_start  = accept && is_iterative(op_in);
        load_simple = accept && !is_iterative(op_in);
        load_iter   = (state_q == ST_BUSY) && core_done;
    end

    always_comb begin
        simple_res = '0;
        case (op_in)
            OP_AND:  simple_res = A & B;
            OP_OR:   simple_res = A | B;
            OP_ADD:  simple_res = A + B;
            OP_SUB:  simple_res = A - B;
            OP_XOR:  simple_res = A ^ B;
            OP_NOT:  simple_res = ~A;
            OP_MOVB: simple_res = B;
            OP_SLL:  simple_res = A << shamt;
            OP_SRL:  simple_res = A >> shamt;
            OP_SRA:  simple_res = $signed(A) >>> shamt;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, A < B};
            OP_SLTS: simple_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            default: simple_res = '0;
        endcase
    end

    // MUL and DIV live in the low half of the engine; MULHU and MOD in the high half.
    assign iter_res = (op_q == OP_MUL || op_q == OP_DIV) ? core_lo : core_hi;

    alu_iter_core #(.XLEN(XLEN)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .op        (op_in),
        .a         (A),
        .b         (B),
        .done      (core_done),
        .result_lo (core_lo),
        .result_hi (core_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_AND;
            b_zero_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_DONE);
            if (accept) begin
                op_q     <= op_in;
                b_zero_q <= (B == '0);
            end
            if (load_simple) begin
                result_q <= simple_res;
                zero_q   <= (simple_res == '0);
                dbz_q    <= 1'b0;
            end else if (load_iter) begin
                result_q <= iter_res;
                zero_q   <= (iter_res == '0);
                dbz_q    <= b_zero_q && is_divide(op_q);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_result  = result_q;
    assign zero_flag   = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at XLEN 32 and 8: directed cases plus random ops checked
// against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, sel8;
    logic [3:0]  ctrl;
    logic [31:0] a_in, b_in;

    logic        iv32, ir32, ov32, zf32, dbz32;
    logic [31:0] res32;
    logic        iv8, ir8, ov8, zf8, dbz8;
    logic [7:0]  res8;

    logic        ir, ov, zf, dbz;
    logic [31:0] res;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign iv32 = in_valid & ~sel8;
    assign iv8  = in_valid & sel8;
    assign ir   = sel8 ? ir8 : ir32;
    assign ov   = sel8 ? ov8 : ov32;
    assign zf   = sel8 ? zf8 : zf32;
    assign dbz  = sel8 ? dbz8 : dbz32;
    assign res  = sel8 ? {24'b0, res8} : res32;

    alu_mc #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .alu_control(ctrl), .A(a_in), .B(b_in), .out_valid(ov32),
        .out_ready(out_ready), .alu_result(res32), .zero_flag(zf32),
        .div_by_zero(dbz32)
    );

    alu_mc #(.XLEN(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .alu_control(ctrl), .A(a_in[7:0]), .B(b_in[7:0]), .out_valid(ov8),
        .out_ready(out_ready), .alu_result(res8), .zero_flag(zf8),
        .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, result} computed with plain wide arithmetic.
    function automatic logic [32:0] ref_alu(input int w, input alu_op_e op,
                                            input logic [31:0] a_raw, input logic [31:0] b_raw);
        longint unsigned mask, a, b, r;
        longint          sa, sb;
        int              sh;
        mask = (64'd1 << w) - 1;
        a    = a_raw & mask;
        b    = b_raw & mask;
        sh   = int'(b % longint'(w));
        sa   = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_XOR:   r = a ^ b;
            OP_NOT:   r = ~a;
            OP_MOVB:  r = b;
            OP_SLL:   r = a << sh;
            OP_SRL:   r = a >> sh;
            OP_SRA:   r = longint'(sa >>> sh);
            OP_SLT:   r = (a < b) ? 1 : 0;
            OP_SLTS:  r = (sa < sb) ? 1 : 0;
            OP_MUL:   r = a * b;
            OP_MULHU: r = (a * b) >> w;
            OP_DIV:   r = (b == 0) ? mask : a / b;
            OP_MOD:   r = (b == 0) ? a : a % b;
            default:  r = 0;
        endcase
        r = r & mask;
        return {(op == OP_DIV || op == OP_MOD) && b == 0, r[31:0]};
    endfunction

    // Issue one op with out_ready high, wait for its result, check value/flags/latency.
    task automatic run_op(input logic use8, input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int          w;
        int          guard;
        int          lat;
        logic        busy_ready_seen;
        logic [32:0] exp;
        w = use8 ? 8 : 32;
        sel8 = use8; ctrl = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        guard = 0;
        while (ir !== 1'b1 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, " in_ready"}, ir, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = $urandom; b_in = $urandom; ctrl = 4'($urandom_range(0, 15));
        lat = 1;
        busy_ready_seen = 1'b0;
        while (ov !== 1'b1 && lat < 200) begin
            if (ir !== 1'b0) busy_ready_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        exp = ref_alu(w, op, a, b);
        check({tag, " result"}, res, exp[31:0]);
        check({tag, " zero_flag"}, zf, exp[31:0] == 0);
        check({tag, " div_by_zero"}, dbz, exp[32]);
        check({tag, " latency"}, lat, is_iterative(op) ? w + 1 : 1);
        if (is_iterative(op)) check({tag, " in_ready during busy"}, busy_ready_seen, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        alu_op_e     rop;
        logic        seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0;
        ctrl = 4'd0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset out_valid", ov, 0);
        check("reset alu_result", res, 0);
        check("reset zero_flag", zf, 0);
        check("reset div_by_zero", dbz, 0);
        check("reset in_ready", ir, 1);

        run_op(0, OP_ADD,   32'd5,        32'd7, "add");
        run_op(0, OP_SUB,   32'd9,        32'd9, "sub");
        run_op(0, OP_SRA,   32'h80000000, 32'd4, "sra");
        run_op(0, OP_SLT,   32'hFFFFFFFF, 32'd1, "slt");
        run_op(0, OP_SLTS,  32'hFFFFFFFF, 32'd1, "slts");
        run_op(0, OP_MUL,   32'hFFFFFFFF, 32'd2, "mul");
        run_op(0, OP_MULHU, 32'hFFFFFFFF, 32'd2, "mulhu");
        run_op(0, OP_DIV,   32'd100,      32'd7, "div");
        run_op(0, OP_MOD,   32'd100,      32'd7, "mod");
        run_op(0, OP_DIV,   32'd100,      32'd0, "div0");
        run_op(0, OP_MOD,   32'd100,      32'd0, "mod0");

        // Back-to-back ADDs, one per cycle.
        sel8 = 1'b0; out_ready = 1'b1; in_valid = 1'b1; ctrl = OP_ADD; b_in = 32'd10;
        for (int i = 0; i < 4; i++) begin
            a_in = 32'(i * 3);
            @(posedge clk); #1;
            check("b2b out_valid", ov, 1);
            check("b2b result", res, 32'(i * 3 + 10));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure: result held while out_ready is low; pending op is ignored.
        ctrl = OP_ADD; a_in = 32'd3; b_in = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        ctrl = OP_SUB; a_in = 32'd20; b_in = 32'd5;
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", ov, 1);
            check("hold result", res, 7);
            check("hold zero_flag", zf, 0);
            check("hold in_ready", ir, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", ir, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release out_valid", ov, 1);
        check("release result", res, 15);
        @(posedge clk); #1;
        check("drain out_valid", ov, 0);

        // Reset on the 10th BUSY cycle of a DIV.
        ctrl = OP_DIV; a_in = 32'd1000; b_in = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("busy before reset", ir, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort out_valid", ov, 0);
        check("abort alu_result", res, 0);
        check("abort in_ready", ir, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov === 1'b1) seen = 1'b1;
        end
        check("abort no result", seen, 0);
        run_op(0, OP_ADD, 32'd40, 32'd2, "add after abort");

        run_op(1, OP_MUL, 32'h0F, 32'h11, "w8 mul");
        run_op(1, OP_DIV, 32'hFF, 32'h10, "w8 div");
        run_op(1, OP_SLL, 32'h81, 32'h0B, "w8 sll");

        for (int i = 0; i < 40; i++) begin
            rop = alu_op_e'(4'($urandom_range(0, 15)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(i >= 28, rop, ra, rb, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
